// File: rtl/rst_seq.sv
`timescale 1ns/1ps
// Staged reset sequencer: qualifies PLL lock, then releases memory, peripheral and CPU resets in order.
// Lock loss or a software request reasserts all three resets together and records the cause.
module rst_seq #(
    parameter int pLockFilt   = 16,
    parameter int pHoldCycles = 16384,
    parameter int pStageGap   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       sw_rst_req,
    output logic       rst_mem,
    output logic       rst_periph,
    output logic       rst_cpu,
    output logic       ready,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count
);

    localparam int CNT_MAX = (pLockFilt > pHoldCycles)
                           ? ((pLockFilt > pStageGap) ? pLockFilt : pStageGap)
                           : ((pHoldCycles > pStageGap) ? pHoldCycles : pStageGap);
    // The counter only ever needs to reach CNT_MAX-1.
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] LOCK_LAST = CW'(pLockFilt - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(pHoldCycles - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(pStageGap - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    typedef enum logic [2:0] {
        WAITLOCK,
        HOLD,
        STAGE1,
        STAGE2,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lk_meta;
    logic          lk_s;
    logic [7:0]    count_inc;
    logic          in_stage;

    assign count_inc = (rst_count == 8'hFF) ? rst_count : rst_count + 8'd1;
    assign in_stage  = (state == STAGE1) || (state == STAGE2);

    // NOTE: every register here uses <= so all flops sample the pre-edge values of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_meta    <= 1'b0;
            lk_s       <= 1'b0;
            state      <= WAITLOCK;
            cnt        <= '0;
            rst_mem    <= 1'b1;
            rst_periph <= 1'b1;
            rst_cpu    <= 1'b1;
            ready      <= 1'b0;
            rst_cause  <= CAUSE_POR;
            rst_count  <= 8'd0;
        end else begin
            lk_meta <= locked;
            lk_s    <= lk_meta;

            case (state)
                WAITLOCK: begin
                    if (!lk_s) begin
                        cnt <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    if (!lk_s) begin
                        // Lock loss outranks a simultaneous software request.
                        state      <= WAITLOCK;
                        cnt        <= '0;
                        rst_mem    <= 1'b1;
                        rst_periph <= 1'b1;
                        rst_cpu    <= 1'b1;
                        ready      <= 1'b0;
                        rst_cause  <= CAUSE_LOCK;
                        if (ready || in_stage) begin
                            rst_count <= count_inc;
                        end
                    end else if (sw_rst_req) begin
                        state      <= HOLD;
                        cnt        <= '0;
                        rst_mem    <= 1'b1;
                        rst_periph <= 1'b1;
                        rst_cpu    <= 1'b1;
                        ready      <= 1'b0;
                        rst_cause  <= CAUSE_SW;
                        rst_count  <= count_inc;
                    end else begin
                        case (state)
                            HOLD: begin
                                if (cnt == HOLD_LAST) begin
                                    rst_mem <= 1'b0;
                                    cnt     <= '0;
                                    state   <= STAGE1;
                                end else begin
                                    cnt <= cnt + CNT_ONE;
                                end
                            end
                            STAGE1: begin
                                if (cnt == GAP_LAST) begin
                                    rst_periph <= 1'b0;
                                    cnt        <= '0;
                                    state      <= STAGE2;
                                end else begin
                                    cnt <= cnt + CNT_ONE;
                                end
                            end
                            STAGE2: begin
                                if (cnt == GAP_LAST) begin
                                    rst_cpu <= 1'b0;
                                    ready   <= 1'b1;
                                    cnt     <= '0;
                                    state   <= RUN;
                                end else begin
                                    cnt <= cnt + CNT_ONE;
                                end
                            end
                            default: begin
                                cnt <= '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
`timescale 1ns/1ps
// Bench for rst_seq: timeline model compared every cycle, plus directed edge-exact expectations.
module tb_rst_seq;

    localparam int F = 4;
    localparam int H = 8;
    localparam int G = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       sw_rst_req;
    logic       rst_mem;
    logic       rst_periph;
    logic       rst_cpu;
    logic       ready;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no  = 0;

    rst_seq #(
        .pLockFilt  (F),
        .pHoldCycles(H),
        .pStageGap  (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .sw_rst_req(sw_rst_req),
        .rst_mem   (rst_mem),
        .rst_periph(rst_periph),
        .rst_cpu   (rst_cpu),
        .ready     (ready),
        .rst_cause (rst_cause),
        .rst_count (rst_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: el is the number of edges elapsed since the hold phase began (-1 while qualifying lock);
    // the three resets are pure threshold functions of el.
    typedef struct {
        int         el;
        int         run;
        bit         lk1;
        bit         lks;
        logic [1:0] cause;
        int         count;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t cur, input bit lk, input bit sw);
        model_t nx;
        nx = cur;
        if (cur.el < 0) begin
            if (cur.lks) begin
                nx.run = cur.run + 1;
                if (nx.run == F) begin
                    nx.el  = 0;
                    nx.run = 0;
                end
            end else begin
                nx.run = 0;
            end
        end else if (!cur.lks) begin
            nx.cause = 2'b01;
            if (cur.el >= H && cur.count < 255) nx.count = cur.count + 1;
            nx.el  = -1;
            nx.run = 0;
        end else if (sw) begin
            nx.cause = 2'b10;
            if (cur.count < 255) nx.count = cur.count + 1;
            nx.el = 0;
        end else if (cur.el < H + 2 * G) begin
            nx.el = cur.el + 1;
        end
        nx.lks = cur.lk1;
        nx.lk1 = lk;
        return nx;
    endfunction

    function automatic logic held(input int el, input int release_at);
        return (el < 0) || (el < release_at);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '{el: -1, run: 0, lk1: 1'b0, lks: 1'b0, cause: 2'b00, count: 0};
        end else begin
            m <= model_step(m, locked, sw_rst_req);
        end
    end

    always @(negedge clk) begin
        check("model_rst_mem",    8'(rst_mem),    8'(held(m.el, H)));
        check("model_rst_periph", 8'(rst_periph), 8'(held(m.el, H + G)));
        check("model_rst_cpu",    8'(rst_cpu),    8'(held(m.el, H + 2 * G)));
        check("model_ready",      8'(ready),      8'(!held(m.el, H + 2 * G)));
        check("model_rst_cause",  8'(rst_cause),  8'(m.cause));
        check("model_rst_count",  rst_count,      8'(m.count));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic goto_edge(input int n);
        while (edge_no < n) tick();
    endtask

    task automatic check_all(input string name, input logic r, input logic [1:0] cause,
                             input logic [7:0] count);
        check({name, "_mem"},    8'(rst_mem),    8'(r));
        check({name, "_periph"}, 8'(rst_periph), 8'(r));
        check({name, "_cpu"},    8'(rst_cpu),    8'(r));
        check({name, "_ready"},  8'(ready),      8'(!r));
        check({name, "_cause"},  8'(rst_cause),  8'(cause));
        check({name, "_count"},  rst_count,      count);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        locked     = 1'b0;
        sw_rst_req = 1'b0;
        #23;
        check_all("por_in_reset", 1'b1, 2'b00, 8'd0);
        rst = 1'b0;
        tick();
        tick();

        // Power-on sequence: locked sampled high from edge 0.
        locked  = 1'b1;
        edge_no = -1;
        goto_edge(12); check("po_mem_e12", 8'(rst_mem), 8'd1);
        goto_edge(13); check("po_mem_e13", 8'(rst_mem), 8'd0);
                       check("po_periph_e13", 8'(rst_periph), 8'd1);
        goto_edge(15); check("po_periph_e15", 8'(rst_periph), 8'd1);
        goto_edge(16); check("po_periph_e16", 8'(rst_periph), 8'd0);
                       check("po_cpu_e16", 8'(rst_cpu), 8'd1);
        goto_edge(18); check("po_ready_e18", 8'(ready), 8'd0);
        goto_edge(19); check_all("po_run_e19", 1'b0, 2'b00, 8'd0);

        // Lock glitch: high at edges 0..2, low at edge 3, high from edge 4.
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        locked = 1'b0;
        tick();
        tick();
        locked  = 1'b1;
        edge_no = -1;
        goto_edge(2);  locked = 1'b0;
        goto_edge(3);  locked = 1'b1;
        goto_edge(13); check("gl_mem_e13", 8'(rst_mem), 8'd1);
        goto_edge(16); check("gl_mem_e16", 8'(rst_mem), 8'd1);
        goto_edge(17); check("gl_mem_e17", 8'(rst_mem), 8'd0);
        goto_edge(19); check("gl_periph_e19", 8'(rst_periph), 8'd1);
        goto_edge(20); check("gl_periph_e20", 8'(rst_periph), 8'd0);
        goto_edge(22); check("gl_ready_e22", 8'(ready), 8'd0);
        goto_edge(23); check_all("gl_run_e23", 1'b0, 2'b00, 8'd0);

        // Lock loss in RUN: raw low sampled at edge 31.
        goto_edge(30); locked = 1'b0;
        goto_edge(32); check_all("ll_e32", 1'b0, 2'b00, 8'd0);
        goto_edge(33); check_all("ll_e33", 1'b1, 2'b01, 8'd1);
        goto_edge(39); locked = 1'b1;
        goto_edge(52); check("rl_mem_e52", 8'(rst_mem), 8'd1);
        goto_edge(53); check("rl_mem_e53", 8'(rst_mem), 8'd0);
        goto_edge(59); check_all("rl_run_e59", 1'b0, 2'b01, 8'd1);

        // Software reset in RUN sampled at edge 71.
        goto_edge(70); sw_rst_req = 1'b1;
        goto_edge(71); sw_rst_req = 1'b0;
        check_all("sw_e71", 1'b1, 2'b10, 8'd2);
        goto_edge(78); check("sw_mem_e78", 8'(rst_mem), 8'd1);
        goto_edge(79); check("sw_mem_e79", 8'(rst_mem), 8'd0);
        goto_edge(85); check_all("sw_run_e85", 1'b0, 2'b10, 8'd2);

        // Simultaneous lock loss and software request in STAGE1.
        goto_edge(90); sw_rst_req = 1'b1;
        goto_edge(91); sw_rst_req = 1'b0;
        check("sw2_count_e91", rst_count, 8'd3);
        goto_edge(97); locked = 1'b0;
        goto_edge(99); check("sim_mem_e99", 8'(rst_mem), 8'd0);
                       check("sim_periph_e99", 8'(rst_periph), 8'd1);
        sw_rst_req = 1'b1;
        goto_edge(100); sw_rst_req = 1'b0;
        check_all("sim_e100", 1'b1, 2'b01, 8'd4);
        goto_edge(110); check_all("sim_wait_e110", 1'b1, 2'b01, 8'd4);

        // Async reset while in STAGE2 (relock sampled at edge 111).
        locked = 1'b1;
        goto_edge(128);
        check("s2_periph_e128", 8'(rst_periph), 8'd0);
        check("s2_cpu_e128", 8'(rst_cpu), 8'd1);
        #2 rst = 1'b1;
        #1 check_all("async_mid_s2", 1'b1, 2'b00, 8'd0);
        #1 rst = 1'b0;
        edge_no = -1;

        // Saturation: 260 software requests from HOLD onward.
        goto_edge(6);
        for (int i = 1; i <= 260; i++) begin
            sw_rst_req = 1'b1;
            tick();
            sw_rst_req = 1'b0;
            if (i == 254) check("sat_254", rst_count, 8'd254);
            if (i == 255) check("sat_255", rst_count, 8'd255);
            tick();
        end
        check_all("sat_260", 1'b1, 2'b10, 8'd255);
        repeat (16) tick();
        check_all("sat_run", 1'b0, 2'b10, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
